pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Parametrised hazard, forwarding and pipeline-control unit for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It keeps its own shadow scoreboard of the instructions in EX, MEM and WB, and from it produces:
- stall, flush and forwarding selects for the IF_ID/ID_EX pipeline registers and the operand muxes;
- a syscall-exit drain sequence;
- optional performance counters.

The current core has no such block; stalls and forwarding are absent.

## Interface
Parameters:
- REG_AW, 5, register-address width
- CNT_W, 32, width of each performance counter

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  REG_AW  ID source registers
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs / rt
- id_writereg  in  REG_AW  ID destination (post RegDst/JAL mux)
- id_regwrite, id_memread  in  1  ID instruction writes reg / is a load
- id_branch  in  1  ID instruction resolves in ID (beq/bne/jr)
- pc_src  in  1  taken branch/jump resolved in ID this cycle
- halt  in  1  syscall exit decoded in ID
- stall_f, stall_d  out  1  hold PC / hold IF_ID
- flush_d  out  1  clear IF_ID to bubble
- flush_e  out  1  clear ID_EX to bubble
- fwd_a_e, fwd_b_e  out  2  EX operand select: 00 regfile, 01 WB Result, 10 MEM ALUOut
- fwd_a_d, fwd_b_d  out  1  ID comparator select: 0 regfile, 1 MEM ALUOut
- drained  out  1  halted and pipeline empty
- cnt_cycles, cnt_retired, cnt_stalls, cnt_flushes  out  CNT_W  performance counters

## Operation
- Shadow state:
  - EX: {v, rs, rt, wr, rw, mr}
  - MEM: {v, wr, rw, mr}
  - WB: {v, wr, rw}
  - plus `halted` and a 2-bit drain counter.
- Every cycle: WB <= MEM and MEM <= EX. EX <= ID fields with v = id_valid & ~flush_e.
- A stage "writes r" iff v & rw & wr == r & r != 0. Register $0 never produces a hazard or a forward.
- Load-use stall: id_valid, and (uses_rs & EX writes rs & EX.mr) or the same condition on rt.
- Branch stall: id_valid & id_branch, with either:
  - EX writes rs/rt (any EX write), or
  - MEM writes rs/rt & MEM.mr.
- stall = load-use | branch stall. When stall is high, stall_f = stall_d = flush_e = 1.
- flush_d = pc_src & ~stall. When stall and pc_src coincide, stall wins: the branch re-resolves next cycle.
- fwd_*_e:
  - 10 if MEM writes EX.rs/rt and ~MEM.mr;
  - otherwise 01 if WB writes it;
  - otherwise 00.
  - MEM has priority over WB.
- fwd_*_d = 1 if MEM writes id_rs/id_rt and ~MEM.mr. WB-to-ID forwarding is the register file's write-before-read.
- Halt FSM:
  - RUN: on halt & ~stall, go to DRAIN.
  - DRAIN: stall_f = stall_d = flush_e = 1 held; the counter counts 3 cycles.
  - Then DONE: drained = 1, which holds until reset.
- Reset mid-operation clears all shadow valids, the FSM and the counters immediately.

## Timing
- stall_*, flush_*, fwd_*_d: combinational from ID inputs and registered shadow state, valid in the same cycle.
- fwd_*_e: combinational from registered shadow state only.
- drained: registered; it rises on the 4th rising edge after the edge that samples halt.
- Load-use costs exactly 1 bubble. Branch-after-ALU costs 1. Branch-after-load costs 2 (EX then MEM).
- Reset values: all outputs 0, fwd selects 00, counters 0, FSM RUN.

## Configuration
- HAZ_STATS_EN defined:
  - cnt_cycles increments every cycle while not DONE.
  - cnt_retired increments when WB.v.
  - cnt_stalls increments on stall cycles.
  - cnt_flushes increments when flush_d.
  - All counters wrap modulo 2^CNT_W.
- HAZ_STATS_EN undefined: no counter flops are built and all cnt_* outputs are tied to 0.

## Test plan
- lw $2 in EX (mr=1, wr=2), ID add uses rs=2 -> stall_f=stall_d=flush_e=1 for 1 cycle; the next cycle fwd_a_e=01.
- add $3 in MEM, add $3 in WB, EX reads rs=3 -> fwd_a_e=10 (MEM priority). With wr=0 in both -> 00.
- beq rs=4 with ALU writer of $4 in EX -> 1 stall. The next cycle fwd_a_d=1, then pc_src=1 -> flush_d=1.
- beq rs=5 after lw $5 -> 2 stall cycles. pc_src asserted during those stalls yields flush_d=0.
- halt pulse -> stall outputs held for 3 cycles, drained=1 on the 4th edge. rst_n low mid-drain -> all outputs 0 asynchronously.
- HAZ_STATS_EN, 10 instructions with 1 load-use and 1 taken branch -> cnt_stalls=1, cnt_flushes=1, cnt_retired=10 at drained.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: ID-stage hazard inputs and pipeline-control outputs of the hazard unit
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic [REG_AW-1:0] id_writereg;
    logic              id_regwrite;
    logic              id_memread;
    logic              id_branch;
    logic              pc_src;
    logic              halt;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        fwd_a_e;
    logic [1:0]        fwd_b_e;
    logic              fwd_a_d;
    logic              fwd_b_d;
    logic              drained;
    logic [CNT_W-1:0]  cnt_cycles;
    logic [CNT_W-1:0]  cnt_retired;
    logic [CNT_W-1:0]  cnt_stalls;
    logic [CNT_W-1:0]  cnt_flushes;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writereg,
               id_regwrite, id_memread, id_branch, pc_src, halt,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, fwd_a_d,
               fwd_b_d, drained, cnt_cycles, cnt_retired, cnt_stalls, cnt_flushes
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_writereg,
               id_regwrite, id_memread, id_branch, pc_src, halt,
        output stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e, fwd_a_d,
               fwd_b_d, drained, cnt_cycles, cnt_retired, cnt_stalls, cnt_flushes
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control with syscall drain; HAZ_STATS_EN adds perf counters
module pipeline_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic              ex_v, ex_rw, ex_mr;
    logic [REG_AW-1:0] ex_rs, ex_rt, ex_wr;
    logic              mem_v, mem_rw, mem_mr;
    logic [REG_AW-1:0] mem_wr;
    logic              wb_v, wb_rw;
    logic [REG_AW-1:0] wb_wr;
    logic [1:0]        state, drain_cnt;
    logic              drained_q;
    logic              ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
    logic              mem_hit_ers, mem_hit_ert, wb_hit_ers, wb_hit_ert;
    logic              load_use, br_stall, stall, hold, flush_d_w;

    function automatic logic wr_hit(input logic v, input logic rw,
                                    input logic [REG_AW-1:0] wr, input logic [REG_AW-1:0] r);
        return v & rw & (wr == r) & (r != '0);
    endfunction

    assign ex_hit_rs   = wr_hit(ex_v, ex_rw, ex_wr, hz.id_rs);
    assign ex_hit_rt   = wr_hit(ex_v, ex_rw, ex_wr, hz.id_rt);
    assign mem_hit_rs  = wr_hit(mem_v, mem_rw, mem_wr, hz.id_rs);
    assign mem_hit_rt  = wr_hit(mem_v, mem_rw, mem_wr, hz.id_rt);
    assign mem_hit_ers = wr_hit(mem_v, mem_rw, mem_wr, ex_rs);
    assign mem_hit_ert = wr_hit(mem_v, mem_rw, mem_wr, ex_rt);
    assign wb_hit_ers  = wr_hit(wb_v, wb_rw, wb_wr, ex_rs);
    assign wb_hit_ert  = wr_hit(wb_v, wb_rw, wb_wr, ex_rt);

    assign load_use  = hz.id_valid & ex_mr & ((hz.id_uses_rs & ex_hit_rs) | (hz.id_uses_rt & ex_hit_rt));
    assign br_stall  = hz.id_valid & hz.id_branch & (ex_hit_rs | ex_hit_rt | (mem_mr & (mem_hit_rs | mem_hit_rt)));
    assign stall     = load_use | br_stall;
    assign hold      = stall | (state == DRAIN);
    assign flush_d_w = hz.pc_src & ~stall;

    assign hz.stall_f = hold;
    assign hz.stall_d = hold;
    assign hz.flush_e = hold;
    assign hz.flush_d = flush_d_w;
    assign hz.fwd_a_e = (mem_hit_ers & ~mem_mr) ? 2'b10 : wb_hit_ers ? 2'b01 : 2'b00;
    assign hz.fwd_b_e = (mem_hit_ert & ~mem_mr) ? 2'b10 : wb_hit_ert ? 2'b01 : 2'b00;
    assign hz.fwd_a_d = mem_hit_rs & ~mem_mr;
    assign hz.fwd_b_d = mem_hit_rt & ~mem_mr;
    assign hz.drained = drained_q;

    // Shadow scoreboard advances every cycle; a flushed ID enters EX as a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v   <= 1'b0;
            ex_rw  <= 1'b0;
            ex_mr  <= 1'b0;
            ex_rs  <= '0;
            ex_rt  <= '0;
            ex_wr  <= '0;
            mem_v  <= 1'b0;
            mem_rw <= 1'b0;
            mem_mr <= 1'b0;
            mem_wr <= '0;
            wb_v   <= 1'b0;
            wb_rw  <= 1'b0;
            wb_wr  <= '0;
        end else begin
            ex_v   <= hz.id_valid & ~hold;
            ex_rw  <= hz.id_regwrite;
            ex_mr  <= hz.id_memread;
            ex_rs  <= hz.id_rs;
            ex_rt  <= hz.id_rt;
            ex_wr  <= hz.id_writereg;
            mem_v  <= ex_v;
            mem_rw <= ex_rw;
            mem_mr <= ex_mr;
            mem_wr <= ex_wr;
            wb_v   <= mem_v;
            wb_rw  <= mem_rw;
            wb_wr  <= mem_wr;
        end
    end

    // Halt FSM: three held drain cycles, then DONE; drained is DONE delayed one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= 2'd0;
            drained_q <= 1'b0;
        end else begin
            drained_q <= (state == DONE);
            if (state == RUN && hz.halt && !stall) begin
                state     <= DRAIN;
                drain_cnt <= 2'd0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + 2'd1;
                if (drain_cnt == 2'd2) state <= DONE;
            end
        end
    end

`ifdef HAZ_STATS_EN
    localparam logic [CNT_W-1:0] ONE = 1;
    logic [CNT_W-1:0] c_cyc, c_ret, c_stl, c_fls;

    // Wrapping event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_cyc <= '0;
            c_ret <= '0;
            c_stl <= '0;
            c_fls <= '0;
        end else begin
            if (state != DONE) c_cyc <= c_cyc + ONE;
            if (wb_v) c_ret <= c_ret + ONE;
            if (stall) c_stl <= c_stl + ONE;
            if (flush_d_w) c_fls <= c_fls + ONE;
        end
    end

    assign hz.cnt_cycles  = c_cyc;
    assign hz.cnt_retired = c_ret;
    assign hz.cnt_stalls  = c_stl;
    assign hz.cnt_flushes = c_fls;
`else
    assign hz.cnt_cycles  = {CNT_W{1'b0}};
    assign hz.cnt_retired = {CNT_W{1'b0}};
    assign hz.cnt_stalls  = {CNT_W{1'b0}};
    assign hz.cnt_flushes = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for hazard, forwarding, drain and counters
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();
    pipeline_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .hz(bus));

    typedef struct packed {
        logic v;
        logic [4:0] rs, rt;
        logic urs, urt;
        logic [4:0] wr;
        logic rw, mr, br;
    } ins_t;

    typedef struct packed {
        logic st, fd;
        logic [1:0] ae, be;
        logic ad, bd, dr;
    } ex_t;

    typedef struct {
        string tag;
        ex_t e;
    } sb_t;

    sb_t sbq[$];
    int errs = 0;
    int checks = 0;
    int edges = 0;
    int exp_cycles = 0;
    ins_t t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic ins_t alu(input int d, input int s, input int r);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(r); i.urs = 1'b1; i.urt = 1'b1; i.wr = 5'(d); i.rw = 1'b1;
        return i;
    endfunction

    function automatic ins_t lw(input int d, input int b);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rs = 5'(b); i.urs = 1'b1; i.wr = 5'(d); i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    function automatic ins_t beq(input int s, input int r);
        ins_t i;
        i = '0;
        i.v = 1'b1; i.rs = 5'(s); i.rt = 5'(r); i.urs = 1'b1; i.urt = 1'b1; i.br = 1'b1;
        return i;
    endfunction

    function automatic ins_t sys();
        ins_t i;
        i = '0;
        i.v = 1'b1;
        return i;
    endfunction

    function automatic ex_t ex(input int st, input int fd, input int ae, input int be,
                               input int ad, input int bd, input int dr);
        ex_t e;
        e.st = 1'(st); e.fd = 1'(fd); e.ae = 2'(ae); e.be = 2'(be);
        e.ad = 1'(ad); e.bd = 1'(bd); e.dr = 1'(dr);
        return e;
    endfunction

    task automatic set_id(input ins_t i, input logic pcs, input logic h);
        bus.id_valid    = i.v;
        bus.id_rs       = i.rs;
        bus.id_rt       = i.rt;
        bus.id_uses_rs  = i.urs;
        bus.id_uses_rt  = i.urt;
        bus.id_writereg = i.wr;
        bus.id_regwrite = i.rw;
        bus.id_memread  = i.mr;
        bus.id_branch   = i.br;
        bus.pc_src      = pcs;
        bus.halt        = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic cyc(input string tag, input ins_t i, input logic pcs, input logic h, input ex_t e);
        sb_t s;
        set_id(i, pcs, h);
        s.tag = tag;
        s.e = e;
        sbq.push_back(s);
        tick();
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) cyc("nop", '0, 1'b0, 1'b0, ex(0, 0, 0, 0, 0, 0, 0));
    endtask

    always @(negedge clk) begin
        sb_t s;
        if (sbq.size() != 0) begin
            s = sbq.pop_front();
            check({s.tag, ".stall_f"}, 32'(bus.stall_f), 32'(s.e.st));
            check({s.tag, ".stall_d"}, 32'(bus.stall_d), 32'(s.e.st));
            check({s.tag, ".flush_e"}, 32'(bus.flush_e), 32'(s.e.st));
            check({s.tag, ".flush_d"}, 32'(bus.flush_d), 32'(s.e.fd));
            check({s.tag, ".fwd_a_e"}, 32'(bus.fwd_a_e), 32'(s.e.ae));
            check({s.tag, ".fwd_b_e"}, 32'(bus.fwd_b_e), 32'(s.e.be));
            check({s.tag, ".fwd_a_d"}, 32'(bus.fwd_a_d), 32'(s.e.ad));
            check({s.tag, ".fwd_b_d"}, 32'(bus.fwd_b_d), 32'(s.e.bd));
            check({s.tag, ".drained"}, 32'(bus.drained), 32'(s.e.dr));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_id('0, 1'b0, 1'b0);
        #12;
        check("rst.stall_f", 32'(bus.stall_f), 0);
        check("rst.flush_d", 32'(bus.flush_d), 0);
        check("rst.flush_e", 32'(bus.flush_e), 0);
        check("rst.fwd_a_e", 32'(bus.fwd_a_e), 0);
        check("rst.fwd_b_e", 32'(bus.fwd_b_e), 0);
        check("rst.fwd_a_d", 32'(bus.fwd_a_d), 0);
        check("rst.drained", 32'(bus.drained), 0);
        check("rst.cnt_cycles", bus.cnt_cycles, 0);
        rst_n = 1'b1;
        tick();
        // load-use on rs, then WB forward
        cyc("lu_lw",    lw(2, 1),     0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("lu_stall", alu(3, 2, 4), 0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("lu_retry", alu(3, 2, 4), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("lu_fwd",   '0,           0, 0, ex(0, 0, 1, 0, 0, 0, 0));
        // load-use on rt, load to $0, and unused operand
        cyc("lu_rt_lw", lw(7, 1),     0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("lu_rt",    alu(8, 9, 7), 0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("lu_x0",    lw(0, 1),     0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("lu_r0",    alu(5, 0, 0), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("lu_lw9",   lw(9, 1),     0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        t = alu(4, 9, 9);
        t.urs = 1'b0;
        t.urt = 1'b0;
        cyc("lu_nouse", t,            0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        nops(3);
        // MEM over WB priority, then $0 never forwards
        cyc("mp_a",   alu(3, 1, 1), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("mp_b",   alu(3, 1, 1), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("mp_rd",  alu(5, 3, 3), 0, 0, ex(0, 0, 0, 0, 1, 1, 0));
        cyc("mp_fwd", '0,           0, 0, ex(0, 0, 2, 2, 0, 0, 0));
        cyc("mp_nop", '0,           0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("z_a",    alu(0, 1, 1), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("z_b",    alu(0, 1, 1), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("z_rd",   alu(5, 0, 0), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("z_fwd",  '0,           0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("wb_x",   alu(7, 2, 5), 0, 0, ex(0, 0, 0, 0, 0, 1, 0));
        cyc("wb_fwd", '0,           0, 0, ex(0, 0, 0, 1, 0, 0, 0));
        nops(2);
        // branch after ALU: one stall (stall beats pc_src), then ID forward and flush
        cyc("ba_add",   alu(4, 1, 1), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("ba_stall", beq(4, 6),    1, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("ba_take",  beq(4, 6),    1, 0, ex(0, 1, 2, 0, 1, 0, 0));
        cyc("ba_fl",    '0,           0, 0, ex(0, 0, 1, 0, 0, 0, 0));
        nops(2);
        // branch after load: two stalls, flush only once resolved
        cyc("bl_lw",   lw(5, 1),  0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("bl_s1",   beq(5, 0), 1, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("bl_s2",   beq(5, 0), 1, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("bl_take", beq(5, 0), 1, 0, ex(0, 1, 1, 0, 0, 0, 0));
        cyc("bl_fl",   '0,        0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        nops(2);
        // halt drain
        cyc("h_sys",   sys(), 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("h_d1",    '0,    0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("h_d2",    '0,    0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("h_d3",    '0,    0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("h_gap",   '0,    0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("h_done",  '0,    0, 0, ex(0, 0, 0, 0, 0, 0, 1));
        cyc("h_hold",  sys(), 0, 1, ex(0, 0, 0, 0, 0, 0, 1));
        cyc("h_hold2", '0,    0, 0, ex(0, 0, 0, 0, 0, 0, 1));
        // reset, new halt, asynchronous reset mid-drain
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cyc("r_sys", sys(), 0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("r_d1",  '0,    0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        check("r_pre.stall_f", 32'(bus.stall_f), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("r_async.stall_f", 32'(bus.stall_f), 0);
        check("r_async.stall_d", 32'(bus.stall_d), 0);
        check("r_async.flush_e", 32'(bus.flush_e), 0);
        check("r_async.flush_d", 32'(bus.flush_d), 0);
        check("r_async.drained", 32'(bus.drained), 0);
        check("r_async.cnt_cycles", bus.cnt_cycles, 0);
        check("r_async.cnt_retired", bus.cnt_retired, 0);
        #2;
        rst_n = 1'b1;
        edges = 0;
        tick();
        // ten-instruction program with one load-use and one taken branch
        cyc("p1",  alu(1, 8, 9), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("p2",  lw(2, 1),     0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("p3s", alu(3, 2, 1), 0, 0, ex(1, 0, 2, 0, 0, 1, 0));
        cyc("p3",  alu(3, 2, 1), 0, 0, ex(0, 0, 0, 1, 0, 0, 0));
        cyc("p4",  alu(4, 8, 9), 0, 0, ex(0, 0, 1, 0, 0, 0, 0));
        cyc("p5b", beq(6, 7),    1, 0, ex(0, 1, 0, 0, 0, 0, 0));
        cyc("p5f", '0,           0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("p6",  alu(5, 8, 9), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("p7",  alu(6, 8, 9), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("p8",  alu(7, 8, 9), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("p9",  alu(8, 8, 9), 0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("p10", sys(),        0, 1, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("pd1", '0,           0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("pd2", '0,           0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("pd3", '0,           0, 0, ex(1, 0, 0, 0, 0, 0, 0));
        exp_cycles = edges;
        cyc("pgap",  '0,         0, 0, ex(0, 0, 0, 0, 0, 0, 0));
        cyc("pdone", '0,         0, 0, ex(0, 0, 0, 0, 0, 0, 1));
`ifdef HAZ_STATS_EN
        check("cnt_cycles",  bus.cnt_cycles,  32'(exp_cycles));
        check("cnt_retired", bus.cnt_retired, 10);
        check("cnt_stalls",  bus.cnt_stalls,  1);
        check("cnt_flushes", bus.cnt_flushes, 1);
`else
        check("cnt_cycles",  bus.cnt_cycles,  0);
        check("cnt_retired", bus.cnt_retired, 0);
        check("cnt_stalls",  bus.cnt_stalls,  0);
        check("cnt_flushes", bus.cnt_flushes, 0);
`endif
        @(negedge clk);
        #1;
        check("sb_empty", 32'(sbq.size()), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
